// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//   ADDR_W / DATA_W / DEPTH : default geometry of the word store
//   state_t                 : responder FSM states
package mem_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 2048;

  // Bytes per word assembled by the program loader
  localparam int unsigned BYTES_PER_WORD = 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ram_2048x24.sv
// Word store: single write port, synchronous registered read.
//   clk    : clock
//   reset  : clears the read register only (array contents are kept)
//   we     : write enable; waddr/wdata written on the rising edge
//   re     : read enable; rdata <= mem[raddr] on the rising edge
//   rdata  : registered read data, holds when re=0
module ram_2048x24 #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Processor-facing word memory with a byte-stream program loader.
//   clk, reset              : clock, synchronous active-high reset
//   memread, memwrite       : processor request strobes
//   address, writedata      : processor word address / write data
//   memdata                 : registered read data to processor
//   load_en                 : level, selects the loader over the processor
//   load_valid, load_byte   : loader byte stream
//   load_ready              : loader accepts a byte this cycle (LOAD only)
//   load_addr               : next word address the loader will write
//   load_done               : sticky, set once word DEPTH-1 is loaded
module memory_responder #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_done
);

  import mem_pkg::*;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [15:0] partial;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;

  // A byte is taken only while still loading; dropping load_en wins over
  // a coincident valid byte so a discarded word is never written.
  logic byte_take;
  assign byte_take = (state == LOAD) && load_en && load_valid;

  // Port arbitration. Reset gates both strobes so no write lands on a
  // reset edge.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = address;
    ram_wdata = writedata;
    if (!reset) begin
      if (state == RUN) begin
        ram_we = memwrite;
        ram_re = memread && !memwrite;
      end else if (byte_take && (byte_idx == 2'd2)) begin
        ram_we    = 1'b1;
        ram_waddr = load_addr;
        ram_wdata = DATA_W'({load_byte, partial});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      load_ready <= 1'b0;
      load_addr  <= '0;
      load_done  <= 1'b0;
      byte_idx   <= '0;
      partial    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (load_en && !load_done) begin
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (!load_en) begin
            state      <= RUN;
            load_ready <= 1'b0;
            byte_idx   <= '0;
            partial    <= '0;
          end else if (load_valid) begin
            case (byte_idx)
              2'd0: begin
                partial[7:0] <= load_byte;
                byte_idx     <= 2'd1;
              end
              2'd1: begin
                partial[15:8] <= load_byte;
                byte_idx      <= 2'd2;
              end
              default: begin
                byte_idx  <= '0;
                partial   <= '0;
                // Increment wraps to 0 after DEPTH-1 since DEPTH == 2**ADDR_W
                load_addr <= load_addr + 1'b1;
                if (load_addr == ADDR_W'(DEPTH - 1)) begin
                  load_done  <= 1'b1;
                  state      <= DONE;
                  load_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        DONE: begin
          if (!load_en) begin
            state <= RUN;
          end
        end
        default: begin
          state      <= RUN;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  ram_2048x24 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (address),
    .rdata (memdata)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [10:0] address;
  logic [23:0] writedata;
  logic [23:0] memdata;
  logic        load_en;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic [10:0] load_addr;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_responder #(
    .ADDR_W (11),
    .DATA_W (24),
    .DEPTH  (2048)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .writedata  (writedata),
    .memdata    (memdata),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_done  (load_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic proc_write(input logic [10:0] a, input logic [23:0] d);
    memwrite  = 1'b1;
    address   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic proc_read(input logic [10:0] a);
    memread = 1'b1;
    address = a;
    tick();
    memread = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; address = '0; writedata = '0;
    load_en = 1'b0; load_valid = 1'b0; load_byte = '0;
    tick(); tick();
    check("rst_memdata", 32'(memdata), 32'h0);
    check("rst_load_addr", 32'(load_addr), 32'h0);
    check("rst_load_done", 32'(load_done), 32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h0);
    reset = 1'b0;
    tick();

    // Basic write then read
    proc_write(11'd5, 24'hABCDEF);
    check("write_holds_memdata", 32'(memdata), 32'h0);
    proc_read(11'd5);
    check("read5", 32'(memdata), 32'hABCDEF);
    tick();
    check("idle_holds", 32'(memdata), 32'hABCDEF);

    // Simultaneous read+write: write only
    memread = 1'b1;
    proc_write(11'd9, 24'h000123);
    memread = 1'b0;
    check("rw_holds", 32'(memdata), 32'hABCDEF);
    proc_read(11'd9);
    check("read9", 32'(memdata), 32'h000123);

    proc_write(11'd7, 24'h777777);
    proc_write(11'd3, 24'h5A5A5A);

    // First loaded word, processor traffic ignored during load
    load_en = 1'b1;
    tick();
    check("load_ready", 32'(load_ready), 32'h1);
    memwrite = 1'b1; memread = 1'b1; address = 11'd7; writedata = 24'hFFFFFF;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    memwrite = 1'b0; memread = 1'b0;
    check("load_addr1", 32'(load_addr), 32'h1);
    check("load_memdata_hold", 32'(memdata), 32'h000123);
    // Words 1 and 2
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    check("load_addr3", 32'(load_addr), 32'h3);
    load_en = 1'b0;
    tick();
    check("run_ready0", 32'(load_ready), 32'h0);
    proc_read(11'd0);
    check("mem0", 32'(memdata), 32'h332211);
    proc_read(11'd7);
    check("mem7_untouched", 32'(memdata), 32'h777777);
    proc_read(11'd2);
    check("mem2", 32'(memdata), 32'h060504);

    // Partial word discarded
    load_en = 1'b1;
    tick();
    send_byte(8'hAA); send_byte(8'hBB);
    load_en = 1'b0;
    tick();
    check("partial_addr", 32'(load_addr), 32'h3);
    check("partial_ready0", 32'(load_ready), 32'h0);
    proc_read(11'd3);
    check("mem3_unchanged", 32'(memdata), 32'h5A5A5A);
    load_en = 1'b1;
    tick();
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    check("resume_addr", 32'(load_addr), 32'h4);
    load_en = 1'b0;
    tick();
    proc_read(11'd3);
    check("mem3_resumed", 32'(memdata), 32'h665544);

    // Reset mid-load, with a third byte and a processor write on the reset edge
    load_en = 1'b1;
    tick();
    send_byte(8'hC1); send_byte(8'hC2);
    reset = 1'b1; load_valid = 1'b1; load_byte = 8'hC3;
    memwrite = 1'b1; address = 11'd5; writedata = 24'h000000;
    tick();
    reset = 1'b0; load_valid = 1'b0; memwrite = 1'b0; load_en = 1'b0;
    check("midrst_memdata", 32'(memdata), 32'h0);
    check("midrst_load_addr", 32'(load_addr), 32'h0);
    check("midrst_load_done", 32'(load_done), 32'h0);
    check("midrst_ready", 32'(load_ready), 32'h0);
    tick();
    proc_read(11'd0);
    check("post_rst_mem0", 32'(memdata), 32'h332211);
    proc_read(11'd3);
    check("post_rst_mem3", 32'(memdata), 32'h665544);
    proc_read(11'd5);
    check("post_rst_mem5", 32'(memdata), 32'hABCDEF);

    // Full image load: byte k carries k mod 256
    load_en = 1'b1;
    tick();
    for (int k = 0; k < 6143; k++) begin
      send_byte(8'(k));
    end
    check("done_before_last", 32'(load_done), 32'h0);
    check("addr_before_last", 32'(load_addr), 32'd2047);
    send_byte(8'hFF);
    check("full_done", 32'(load_done), 32'h1);
    check("full_addr_wrap", 32'(load_addr), 32'h0);
    check("full_ready0", 32'(load_ready), 32'h0);
    check("full_memdata_hold", 32'(memdata), 32'hABCDEF);
    tick();
    check("done_stays", 32'(load_ready), 32'h0);
    load_en = 1'b0;
    tick();
    proc_read(11'd2047);
    check("mem2047", 32'(memdata), 32'hFFFEFD);
    proc_read(11'd0);
    check("full_mem0", 32'(memdata), 32'h020100);
    proc_read(11'd100);
    check("full_mem100", 32'(memdata), 32'h2E2D2C);
    check("done_sticky", 32'(load_done), 32'h1);

    // Reasserting load_en after completion stays in RUN
    load_en = 1'b1;
    tick(); tick();
    check("relaunch_ignored", 32'(load_ready), 32'h0);
    check("relaunch_addr", 32'(load_addr), 32'h0);
    load_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width.
REQ-002 Parameter DATA_W, default 24, word width.
REQ-003 Parameter DEPTH, default 2048, number of words (2**ADDR_W).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 memread  input  1  processor read request, sampled each cycle.
REQ-007 memwrite  input  1  processor write request, sampled each cycle.
REQ-008 address  input  11  processor word address.
REQ-009 writedata  input  24  processor write data.
REQ-010 memdata  output  24  registered read data to processor.
REQ-011 load_en  input  1  level; selects the byte-loader port over the processor port.
REQ-012 load_valid  input  1  load_byte is valid this cycle.
REQ-013 load_byte  input  8  program-image byte.
REQ-014 load_ready  output  1  loader accepts a byte this cycle.
REQ-015 load_addr  output  11  next word address the loader will write.
REQ-016 load_done  output  1  sticky; set when the loader has written word DEPTH-1.

Function
REQ-017 FSM states: RUN, LOAD, DONE.
REQ-018 RUN: processor read (memread=1, memwrite=0) SHALL present mem[address] on memdata exactly one cycle later.
REQ-019 RUN: processor write (memwrite=1) SHALL store writedata at address on that edge; memdata holds its prior value.
REQ-020 memread=1 and memwrite=1 together: the write is performed and no read occurs; memdata holds.
REQ-021 memdata holds its last value on every cycle with no read, including all cycles in LOAD and DONE.
REQ-022 RUN -> LOAD when load_en=1; processor requests are ignored (no writes, no reads) in LOAD and DONE.
REQ-023 load_ready=1 only in LOAD; a byte is accepted on an edge with load_valid=1 and load_ready=1.
REQ-024 Bytes assemble little-endian: the first byte goes to bits [7:0], the second to [15:8], the third to [23:16]; a 2-bit byte index counts 0, 1, 2.
REQ-025 On the edge accepting the third byte, the assembled word is written to mem[load_addr], load_addr increments, and the byte index returns to 0.
REQ-026 When the word at load_addr=DEPTH-1 is written: load_addr wraps to 0, load_done is set, and the FSM moves to DONE.
REQ-027 DONE -> RUN when load_en=0; load_done stays set until reset.
REQ-028 LOAD with load_en deasserted mid-word: the partial word is discarded, the byte index clears, load_addr is retained, and the FSM returns to RUN.
REQ-029 Reasserting load_en from RUN with load_done=0 resumes loading at the retained load_addr.
REQ-030 Reasserting load_en from RUN with load_done=1 is ignored; the FSM stays in RUN.
REQ-031 Addresses are unsigned; no out-of-range access is possible because DEPTH=2**ADDR_W.

Reset
REQ-032 Reset SHALL set memdata=0, load_addr=0, byte index=0, partial word=0, load_done=0, load_ready=0 and the FSM to RUN.
REQ-033 Reset overrides any simultaneous request; no write occurs on a reset edge.
REQ-034 Reset SHALL NOT clear the storage array contents.
REQ-035 Reset asserted mid-load abandons the load; loading restarts at address 0.

Structure
REQ-036 Shared package mem_pkg SHALL hold ADDR_W, DATA_W and DEPTH, plus the FSM state enumeration (RUN, LOAD, DONE).
REQ-037 Storage SHALL be the sub-module ram_2048x24: single write port, synchronous registered read.
REQ-038 Port arbitration, the FSM and byte assembly reside in memory_responder.

Verification
REQ-039 Reset; write 24'hABCDEF at address 5; read address 5 -> memdata=24'hABCDEF on the cycle after the read.
REQ-040 memread=1 and memwrite=1 at address 9 with writedata 24'h000123 -> memdata unchanged; a later read of address 9 returns 24'h000123.
REQ-041 load_en=1, bytes 8'h11, 8'h22, 8'h33 -> mem[0]=24'h332211, load_addr=1; processor write during load has no effect.
REQ-042 Load of 6144 bytes -> load_done=1 after the last byte, load_addr=0, FSM in DONE; load_en=0 returns the FSM to RUN.
REQ-043 load_en dropped after 2 bytes at load_addr=3 -> mem[3] unchanged; reassert load_en and send 3 bytes -> word written at address 3.
REQ-044 Reset asserted mid-load -> memdata=0, load_addr=0, load_done=0; previously loaded words are still readable after reset.
